iiitb_gc_ctrl: RTL and testbench
================================

Name: iiitb_gc_ctrl

Overview:
- Command-driven sequencer for the 8-bit gray-code counter in the user project area.
- Accepts CLEAR / STEP / BURST / STOP commands over a valid/ready interface and drives the counter's enable and synchronous clear.
- Observes the counter's gray output and reports done, abort, wrap-around and a binary mirror of the count.
- Sits between the management-side control logic (LA / wishbone glue) and the counter instance.

Parameters:
- WIDTH, 8, counter / gray width.
- LEN_W, 16, width of the burst length field.

Ports:
- clk  input  1  single clock, the counter's clock.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  00 CLEAR, 01 STEP, 10 BURST, 11 STOP.
- cmd_len  input  LEN_W  increment count for BURST; ignored otherwise.
- hold  input  1  pause BURST without losing progress.
- gray_in  input  WIDTH  gray_count from the counter.
- gc_enable  output  1  to counter enable.
- gc_clear  output  1  to counter's synchronous active-high reset.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when a command completes.
- aborted  output  1  valid with done; 1 if the BURST ended by STOP.
- cmd_err  output  1  one-cycle pulse when a non-STOP command is accepted while BURST is active (the command is dropped).
- wrap  output  1  one-cycle pulse when the counter wraps.
- bin_count  output  WIDTH  registered binary equivalent of gray_in.

Behaviour:
- Reset: reset_n low asynchronously forces state IDLE, remaining=0, and the registered outputs done, aborted, cmd_err, wrap, bin_count and gray_prev to 0. gc_enable, gc_clear and busy are 0 in IDLE. A reset mid-BURST discards remaining; no done is issued.
- States: IDLE, CLR, BURST.
- cmd_ready = 1 in IDLE and BURST, 0 in CLR.
- IDLE, accepted command:
  - CLEAR -> CLR.
  - STEP -> BURST with remaining=1.
  - BURST with cmd_len>0 -> BURST with remaining=cmd_len.
  - BURST with cmd_len==0 -> stay IDLE; done=1 (aborted=0) on the next cycle.
  - STOP -> no-op; no done.
- CLR: gc_clear=1 for exactly one cycle, then IDLE; done pulses on the following cycle.
- BURST:
  - gc_enable = !hold && !(cmd_valid && cmd_op==STOP), combinational.
  - Each cycle with gc_enable=1 decrements remaining, and the counter increments on the same edge.
  - On the edge where remaining==1 and gc_enable=1 -> IDLE; done=1, aborted=0 in the next cycle.
  - hold=1 freezes remaining and gc_enable=0; the state stays BURST.
  - Net result: a BURST of N gives exactly N counter increments, independent of hold.
- STOP accepted in BURST:
  - No increment that cycle (this includes a STOP coinciding with the final step).
  - -> IDLE; done=1, aborted=1 next cycle.
- Other commands accepted in BURST: dropped; cmd_err=1 the next cycle; the burst continues.
- Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. bin_count is registered, so it lags gray_in by one cycle.
- Wrap detection:
  - Register gray_prev (previous gray_in).
  - wrap=1 for one cycle when gray_prev == {1'b1,{W-1{1'b0}}} (binary all-ones) and gray_in == 0, i.e. one cycle after the wrap edge.
  - A transition to 0 caused by gc_clear from any other value does not assert wrap.
- Remaining-count arithmetic: unsigned LEN_W; no overflow possible because it only decrements from cmd_len.
- done, aborted, cmd_err and wrap are single-cycle pulses, never held.

Decomposition:
- Package iiitb_gc_pkg: cmd_op encodings (OP_CLEAR, OP_STEP, OP_BURST, OP_STOP), state enum, and default WIDTH / LEN_W constants.
- One combinational sub-module, iiitb_gc_gray2bin (WIDTH parameter), reused by the bench's scoreboard.
- The FSM stays in iiitb_gc_ctrl.

Test Plan:
- Reset then CLEAR: reset_n low 3 cycles, release, CLEAR -> gc_clear high 1 cycle, done 1 cycle later, bin_count=0, busy=0.
- BURST 5, hold=0: exactly 5 gc_enable cycles; bin_count settles at 5 (gray 0x07); done with aborted=0; STEP afterwards -> bin_count=6.
- BURST 10 with hold high for cycles 3-6: 10 total enables, burst duration 14 cycles, final bin_count=10.
- BURST 300 from 0: wrap pulses once after the 256th increment (gray 0x80 -> 0x00); final bin_count=44.
- BURST 20, STOP after the 7th increment: bin_count=7, done with aborted=1; STEP during a burst -> cmd_err pulse and count unaffected; STOP in IDLE -> no done.
- BURST with cmd_len=0 -> done next cycle, no gc_enable. reset_n asserted mid-BURST -> gc_enable drops immediately, busy=0, no done.

Source files
------------

// File: rtl/iiitb_gc_pkg.sv
// Shared definitions for the gray-code counter sequencer.
// - Default counter width and burst-length width.
// - Command opcodes seen on cmd_op.
// - FSM state encodings, kept as plain localparam constants so that
//   older tools can read them.
package iiitb_gc_pkg;

  localparam int GC_WIDTH = 8;
  localparam int GC_LEN_W = 16;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_STEP  = 2'b01,
    OP_BURST = 2'b10,
    OP_STOP  = 2'b11
  } gc_op_e;

  typedef logic [1:0] gc_state_t;

  localparam gc_state_t ST_IDLE  = 2'd0;
  localparam gc_state_t ST_CLR   = 2'd1;
  localparam gc_state_t ST_BURST = 2'd2;

endpackage

// File: rtl/iiitb_gc_gray2bin.sv
// Combinational gray-to-binary converter.
// Ports:
//   gray - reflected-binary input code
//   bin  - equivalent plain binary value
// Bit i of the binary value is the XOR of all gray bits at position i and above.
module iiitb_gc_gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/iiitb_gc_ctrl.sv
// Command-driven sequencer for the gray-code counter.
// Ports:
//   clk, reset_n        - counter clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake (accepted when both are high)
//   cmd_op, cmd_len     - opcode (CLEAR/STEP/BURST/STOP) and BURST length
//   hold                - pauses an active BURST without losing progress
//   gray_in             - gray count fed back from the counter
//   gc_enable, gc_clear - counter enable and synchronous clear
//   busy                - high whenever the sequencer is not idle
//   done, aborted       - completion pulse; aborted marks a STOP-ended BURST
//   cmd_err             - pulse for a non-STOP command dropped during BURST
//   wrap                - pulse one cycle after the counter wraps to zero
//   bin_count           - registered binary mirror of gray_in
module iiitb_gc_ctrl
  import iiitb_gc_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH,
  parameter int LEN_W = GC_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             hold,
  input  logic [WIDTH-1:0] gray_in,
  output logic             gc_enable,
  output logic             gc_clear,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cmd_err,
  output logic             wrap,
  output logic [WIDTH-1:0] bin_count
);

  // Gray code of the all-ones binary value: the last code before a wrap.
  localparam logic [WIDTH-1:0] GRAY_TOP = {1'b1, {(WIDTH-1){1'b0}}};

  gc_state_t        state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             cmd_err_q, cmd_err_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] bin_count_q, bin_count_d;
  logic [WIDTH-1:0] gray_prev_q;

  logic accept;
  logic stop_req;

  iiitb_gc_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (gray_in),
    .bin  (bin_count_d)
  );

  // CLR is the only state that cannot take a command; STOP is acted on
  // combinationally so the counter never steps on the cycle it is accepted.
  assign cmd_ready = (state_q != ST_CLR);
  assign accept    = cmd_valid && cmd_ready;
  assign stop_req  = cmd_valid && (cmd_op == OP_STOP);
  assign gc_clear  = (state_q == ST_CLR);
  assign gc_enable = (state_q == ST_BURST) && !hold && !stop_req;
  assign busy      = (state_q != ST_IDLE);

  assign wrap_d = (gray_prev_q == GRAY_TOP) && (gray_in == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CLEAR: state_d = ST_CLR;
            OP_STEP: begin
              state_d     = ST_BURST;
              remaining_d = LEN_W'(1);
            end
            OP_BURST: begin
              // A zero-length burst completes immediately without moving.
              if (cmd_len != '0) begin
                state_d     = ST_BURST;
                remaining_d = cmd_len;
              end else begin
                done_d = 1'b1;
              end
            end
            default: ; // STOP while idle has nothing to stop
          endcase
        end
      end

      ST_CLR: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      ST_BURST: begin
        if (stop_req) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
          aborted_d   = 1'b1;
        end else begin
          if (accept) begin
            cmd_err_d = 1'b1;
          end
          if (gc_enable) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      bin_count_q <= '0;
      gray_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cmd_err_q   <= cmd_err_d;
      wrap_q      <= wrap_d;
      bin_count_q <= bin_count_d;
      gray_prev_q <= gray_in;
    end
  end

  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cmd_err   = cmd_err_q;
  assign wrap      = wrap_q;
  assign bin_count = bin_count_q;

endmodule

// File: tb/tb_iiitb_gc_ctrl.sv
// Self-checking bench for iiitb_gc_ctrl. The bench owns a behavioural
// model of the 8-bit gray counter (a binary integer that clears/increments
// from the DUT's controls) and derives the expected mirror and wrap pulses
// from that count history. Directed scenarios add literal expectations.
module tb_iiitb_gc_ctrl;
  import iiitb_gc_pkg::*;

  localparam int W  = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          hold;
  logic [W-1:0]  gray_in;
  logic          gc_enable;
  logic          gc_clear;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          cmd_err;
  logic          wrap;
  logic [W-1:0]  bin_count;

  always #5 clk = ~clk;

  iiitb_gc_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .hold      (hold),
    .gray_in   (gray_in),
    .gc_enable (gc_enable),
    .gc_clear  (gc_clear),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cmd_err   (cmd_err),
    .wrap      (wrap),
    .bin_count (bin_count)
  );

  // Counter model: binary count, gray-encoded onto gray_in.
  // h1 = count during the last completed cycle, h2 = the one before.
  logic [W-1:0] model_cnt;
  logic [W-1:0] h1;
  logic [W-1:0] h2;
  logic [W-1:0] ref_bin;

  assign gray_in = model_cnt ^ (model_cnt >> 1);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_cnt <= '0;
      h1        <= '0;
      h2        <= '0;
    end else begin
      h2 <= h1;
      h1 <= model_cnt;
      if (gc_clear)       model_cnt <= '0;
      else if (gc_enable) model_cnt <= model_cnt + 8'd1;
    end
  end

  iiitb_gc_gray2bin #(.WIDTH(W)) u_ref_g2b (
    .gray (gray_in),
    .bin  (ref_bin)
  );

  int checks   = 0;
  int failures = 0;

  // Running tallies, written only by compare_cycle.
  int en_tot    = 0;
  int done_tot  = 0;
  int abort_tot = 0;
  int err_tot   = 0;
  int wrap_tot  = 0;
  int busy_tot  = 0;

  // Snapshots taken by the stimulus.
  int e0, d0, b0, w0, r0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  task automatic compare_cycle();
    check("bin_count_mirror", bin_count, h1);
    check("wrap_pulse", wrap, (h2 == 8'hFF) && (h1 == 8'h00));
    check("g2b_matches_model", ref_bin, model_cnt);
    check("ready_not_in_clear", cmd_ready, !gc_clear);
    check("enable_without_busy", gc_enable && !busy, 0);
    check("enable_with_clear", gc_enable && gc_clear, 0);
    check("aborted_without_done", aborted && !done, 0);
    en_tot    += int'(gc_enable);
    done_tot  += int'(done);
    abort_tot += int'(aborted && done);
    err_tot   += int'(cmd_err);
    wrap_tot  += int'(wrap);
    busy_tot  += int'(busy);
  endtask

  // One clock cycle: compare at the falling edge, return 1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset_n) compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [LW-1:0] len);
    int n;
    n         = 0;
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_accepted", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_within_bound", done, 1);
  endtask

  task automatic clear_counter();
    send(OP_CLEAR, '0);
    tick();
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_CLEAR;
    cmd_len   = '0;
    hold      = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_gc_enable", gc_enable, 0);
    check("rst_gc_clear", gc_clear, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_wrap", wrap, 0);
    check("rst_bin_count", bin_count, 0);
    reset_n = 1'b1;
    tick();

    // CLEAR: one clear cycle, done the cycle after.
    cmd_op    = OP_CLEAR;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("clr_gc_clear", gc_clear, 1);
    check("clr_ready_low", cmd_ready, 0);
    check("clr_busy", busy, 1);
    check("clr_no_early_done", done, 0);
    tick();
    check("clr_gc_clear_one_cycle", gc_clear, 0);
    check("clr_done", done, 1);
    check("clr_not_aborted", aborted, 0);
    check("clr_idle", busy, 0);
    tick();
    check("clr_done_one_cycle", done, 0);
    check("clr_bin_count", bin_count, 0);

    // BURST 5 then STEP.
    e0 = en_tot;
    send(OP_BURST, 16'd5);
    wait_done(20);
    check("b5_not_aborted", aborted, 0);
    tick();
    check("b5_done_one_cycle", done, 0);
    check("b5_bin_count", bin_count, 5);
    check("b5_gray", gray_in, 8'h07);
    check("b5_enables", en_tot - e0, 5);
    send(OP_STEP, '0);
    wait_done(5);
    tick();
    check("step_bin_count", bin_count, 6);

    // BURST 10 with hold over burst cycles 3..6.
    clear_counter();
    e0 = en_tot;
    b0 = busy_tot;
    send(OP_BURST, 16'd10);
    tick();
    tick();
    hold = 1'b1;
    repeat (4) tick();
    hold = 1'b0;
    wait_done(20);
    check("hold_enables", en_tot - e0, 10);
    check("hold_duration", busy_tot - b0, 14);
    tick();
    check("hold_bin_count", bin_count, 10);

    // BURST 300 from zero: one wrap, ends at 300 mod 256.
    clear_counter();
    w0 = wrap_tot;
    send(OP_BURST, 16'd300);
    wait_done(400);
    tick();
    check("b300_bin_count", bin_count, 44);
    check("b300_model_count", model_cnt, 44);
    check("b300_wraps", wrap_tot - w0, 1);

    // BURST 20 stopped after the 7th increment.
    clear_counter();
    e0 = en_tot;
    send(OP_BURST, 16'd20);
    repeat (7) tick();
    cmd_op    = OP_STOP;
    cmd_valid = 1'b1;
    #1;
    check("stop_blocks_enable", gc_enable, 0);
    check("stop_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("stop_done", done, 1);
    check("stop_aborted", aborted, 1);
    check("stop_idle", busy, 0);
    check("stop_enables", en_tot - e0, 7);
    tick();
    check("stop_done_one_cycle", done, 0);
    check("stop_bin_count", bin_count, 7);

    // STEP during a burst is dropped with cmd_err.
    clear_counter();
    e0 = en_tot;
    r0 = err_tot;
    send(OP_BURST, 16'd6);
    cmd_op    = OP_STEP;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("err_pulse", cmd_err, 1);
    tick();
    check("err_one_cycle", cmd_err, 0);
    check("err_burst_continues", busy, 1);
    wait_done(20);
    check("err_not_aborted", aborted, 0);
    tick();
    check("err_bin_count", bin_count, 6);
    check("err_enables", en_tot - e0, 6);
    check("err_count", err_tot - r0, 1);

    // STOP while idle: nothing happens.
    d0 = done_tot;
    send(OP_STOP, '0);
    repeat (3) tick();
    check("idle_stop_no_done", done_tot - d0, 0);
    check("idle_stop_idle", busy, 0);
    check("idle_stop_bin_count", bin_count, 6);

    // Zero-length BURST: done next cycle, never enabled.
    e0        = en_tot;
    cmd_op    = OP_BURST;
    cmd_len   = '0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("len0_done", done, 1);
    check("len0_not_aborted", aborted, 0);
    check("len0_idle", busy, 0);
    tick();
    check("len0_done_one_cycle", done, 0);
    check("len0_enables", en_tot - e0, 0);

    // Reset in the middle of a burst.
    d0 = done_tot;
    send(OP_BURST, 16'd50);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_enable", gc_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_bin_count", bin_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", done_tot - d0, 0);
    check("mid_rst_stays_idle", busy, 0);
    check("mid_rst_count_zero", bin_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
